// File: rtl/gpio_debug_bridge.sv
// GPIO command/response bridge: run/halt/step/reset control of the MIPS pipeline and
// sliced read-back of debug words, handshaked through request/acknowledge toggle bits.
module gpio_debug_bridge #(
  parameter int NB_FRAME   = 32,
  parameter int N_CHANNELS = 8,
  parameter int NB_DATA    = 32,
  parameter int NB_STEP    = 24,
  parameter int RST_CYCLES = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_FRAME-1:0]           i_frame_from_blaze,
  output logic [NB_FRAME-1:0]           o_frame_to_blaze,
  input  logic [N_CHANNELS*NB_DATA-1:0] i_debug_data,
  output logic                          o_pipe_valid,
  output logic                          o_pipe_reset
);
  localparam int NB_RCNT = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int NB_PAD  = 384;

  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, PRST = 2'd2} state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PRST = 3'd1;
  localparam logic [2:0] OP_RUN  = 3'd2;
  localparam logic [2:0] OP_HALT = 3'd3;
  localparam logic [2:0] OP_STEP = 3'd4;
  localparam logic [2:0] OP_READ = 3'd5;

  state_t              state_r, state_s;
  logic [NB_FRAME-1:0] req_r, frame_r, frame_s;
  logic                valid_r, valid_s, prst_r, prst_s, run_r, run_s, tog_r, tog_s;
  logic [NB_STEP-1:0]  step_cnt_r, step_cnt_s;
  logic [NB_RCNT-1:0]  rst_cnt_r, rst_cnt_s;
  logic                new_cmd_s, chan_ok_s;
  logic [2:0]          op_s;
  logic [NB_STEP-1:0]  step_arg_s;
  logic [7:0]          chan_s;
  logic [3:0]          slice_s;
  logic [23:0]         read_data_s;

  // Stepping [28] is always 0 in an ack: every ack ends any step in progress.
  function automatic logic [NB_FRAME-1:0] resp(input logic tog, input logic err,
                                               input logic running, input logic [23:0] data);
    resp = {tog, err, running, 1'b0, 4'b0000, data};
  endfunction

  function automatic logic [23:0] read_slice(input logic [N_CHANNELS*NB_DATA-1:0] bus,
                                             input logic [7:0] chan, input logic [3:0] slice);
    logic [NB_DATA-1:0] word;
    logic [NB_PAD-1:0]  pad;
    word = {NB_DATA{1'b0}};
    for (int k = 0; k < N_CHANNELS; k++) begin
      word = (int'(chan) == k) ? bus[k*NB_DATA +: NB_DATA] : word;
    end
    pad = {NB_PAD{1'b0}};
    pad[NB_DATA-1:0] = word;
    read_slice = 24'h000000;
    for (int s = 0; s < 16; s++) begin
      read_slice = (int'(slice) == s) ? pad[s*24 +: 24] : read_slice;
    end
  endfunction

  // Command field decode; while busy, a new command is one whose toggle differs from the in-flight one.
  always_comb begin
    op_s        = req_r[30:28];
    step_arg_s  = req_r[NB_STEP-1:0];
    chan_s      = req_r[27:20];
    slice_s     = req_r[19:16];
    chan_ok_s   = (int'(chan_s) < N_CHANNELS);
    read_data_s = chan_ok_s ? read_slice(i_debug_data, chan_s, slice_s) : 24'h000000;
    if (state_r == IDLE) begin
      new_cmd_s = (req_r[31] != frame_r[31]);
    end else begin
      new_cmd_s = (req_r[31] != tog_r);
    end
  end

  // Next-state, counters and response frame.
  always_comb begin
    state_s    = state_r;
    frame_s    = frame_r;
    valid_s    = valid_r;
    prst_s     = prst_r;
    run_s      = run_r;
    tog_s      = tog_r;
    step_cnt_s = step_cnt_r;
    rst_cnt_s  = rst_cnt_r;
    case (state_r)
      IDLE: begin
        if (new_cmd_s) begin
          case (op_s)
            OP_NOP: frame_s = resp(req_r[31], 1'b0, run_r, 24'h000000);
            OP_PRST: begin
              run_s     = 1'b0;
              valid_s   = 1'b0;
              prst_s    = 1'b1;
              rst_cnt_s = NB_RCNT'(RST_CYCLES - 1);
              tog_s     = req_r[31];
              state_s   = PRST;
            end
            OP_RUN: begin
              run_s   = 1'b1;
              valid_s = 1'b1;
              frame_s = resp(req_r[31], 1'b0, 1'b1, 24'h000000);
            end
            OP_HALT: begin
              run_s   = 1'b0;
              valid_s = 1'b0;
              frame_s = resp(req_r[31], 1'b0, 1'b0, 24'h000000);
            end
            OP_STEP: begin
              run_s = 1'b0;
              if (step_arg_s == {NB_STEP{1'b0}}) begin
                valid_s = 1'b0;
                frame_s = resp(req_r[31], 1'b0, 1'b0, 24'h000000);
              end else begin
                valid_s    = 1'b1;
                step_cnt_s = step_arg_s - NB_STEP'(1);
                tog_s      = req_r[31];
                state_s    = STEP;
              end
            end
            OP_READ: frame_s = resp(req_r[31], ~chan_ok_s, run_r, read_data_s);
            default: frame_s = resp(req_r[31], 1'b1, run_r, 24'h000000);
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      STEP: begin
        // HALT and PRST preempt a step; the aborted step is never acked on its own.
        if (new_cmd_s && (op_s == OP_HALT)) begin
          valid_s    = 1'b0;
          step_cnt_s = {NB_STEP{1'b0}};
          frame_s    = resp(req_r[31], 1'b0, 1'b0, 24'h000000);
          state_s    = IDLE;
        end else if (new_cmd_s && (op_s == OP_PRST)) begin
          valid_s    = 1'b0;
          step_cnt_s = {NB_STEP{1'b0}};
          prst_s     = 1'b1;
          rst_cnt_s  = NB_RCNT'(RST_CYCLES - 1);
          tog_s      = req_r[31];
          state_s    = PRST;
        end else if (step_cnt_r == {NB_STEP{1'b0}}) begin
          valid_s = 1'b0;
          frame_s = resp(tog_r, 1'b0, 1'b0, 24'h000000);
          state_s = IDLE;
        end else begin
          step_cnt_s = step_cnt_r - NB_STEP'(1);
        end
      end
      PRST: begin
        if (rst_cnt_r == {NB_RCNT{1'b0}}) begin
          prst_s  = 1'b0;
          frame_s = resp(tog_r, 1'b0, 1'b0, 24'h000000);
          state_s = IDLE;
        end else begin
          rst_cnt_s = rst_cnt_r - NB_RCNT'(1);
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        prst_s  = 1'b0;
        run_s   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= IDLE;
      req_r      <= {NB_FRAME{1'b0}};
      frame_r    <= {NB_FRAME{1'b0}};
      valid_r    <= 1'b0;
      prst_r     <= 1'b0;
      run_r      <= 1'b0;
      tog_r      <= 1'b0;
      step_cnt_r <= {NB_STEP{1'b0}};
      rst_cnt_r  <= {NB_RCNT{1'b0}};
    end else begin
      state_r    <= state_s;
      req_r      <= i_frame_from_blaze;
      frame_r    <= frame_s;
      valid_r    <= valid_s;
      prst_r     <= prst_s;
      run_r      <= run_s;
      tog_r      <= tog_s;
      step_cnt_r <= step_cnt_s;
      rst_cnt_r  <= rst_cnt_s;
    end
  end

  assign o_frame_to_blaze = frame_r;
  assign o_pipe_valid     = valid_r;
  assign o_pipe_reset     = prst_r;

endmodule
